// File: rtl/alu_exec_ctrl.sv
// Multi-cycle execute controller for the 9-bit ALU: IDLE -> READ -> EXEC -> WB, with sticky HALT.
// Optional retired-instruction counter enabled by defining ALU_EXEC_CTRL_RETIRE_CNT_EN.
module alu_exec_ctrl #(
  parameter int DW   = 9,
  parameter int NREG = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     instr_valid,
  output logic                     instr_ready,
  input  logic [16:0]              instr,
  output logic [3:0]               alu_op,
  output logic [DW-1:0]            alu_a,
  output logic [DW-1:0]            alu_b,
  input  logic [DW-1:0]            alu_out,
  output logic                     wb_valid,
  output logic [$clog2(NREG)-1:0]  wb_rd,
  output logic [DW-1:0]            wb_data,
  output logic                     halted,
  output logic                     illegal,
  output logic [15:0]              retired_cnt
);

  localparam logic [3:0] OP_NOP  = 4'b1011;
  localparam logic [3:0] OP_HALT = 4'b1111;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_READ = 3'd1,
    S_EXEC = 3'd2,
    S_WB   = 3'd3,
    S_HALT = 3'd4
  } state_e;

  state_e                    state_q, state_d;
  logic [16:0]               instr_q, instr_d;
  logic [3:0]                alu_op_q, alu_op_d;
  logic [DW-1:0]             alu_a_q, alu_a_d;
  logic [DW-1:0]             alu_b_q, alu_b_d;
  logic [DW-1:0]             result_q, result_d;
  logic [DW-1:0]             regs_q [NREG];
  logic [DW-1:0]             regs_d [NREG];
  logic                      instr_ready_q, instr_ready_d;
  logic                      wb_valid_q, wb_valid_d;
  logic [$clog2(NREG)-1:0]   wb_rd_q, wb_rd_d;
  logic [DW-1:0]             wb_data_q, wb_data_d;
  logic                      halted_q, halted_d;
  logic                      illegal_q, illegal_d;

  logic [3:0]                op_s;
  logic [1:0]                rd_s;
  logic [1:0]                rs_s;
  logic [DW-1:0]             imm_s;

  function automatic logic is_write(input logic [3:0] op);
    return (op <= 4'b1010);
  endfunction

  function automatic logic is_undef(input logic [3:0] op);
    return (op >= 4'b1100) && (op <= 4'b1110);
  endfunction

  assign op_s  = instr_q[16:13];
  assign rd_s  = instr_q[12:11];
  assign rs_s  = instr_q[10:9];
  assign imm_s = instr_q[8:0];

`ifdef ALU_EXEC_CTRL_RETIRE_CNT_EN
  logic [15:0] cnt_q, cnt_d;
  assign retired_cnt = cnt_q;
`else
  assign retired_cnt = 16'h0000;
`endif

  // Next-state and datapath update for every controller flop.
  always_comb begin
    state_d       = state_q;
    instr_d       = instr_q;
    alu_op_d      = alu_op_q;
    alu_a_d       = alu_a_q;
    alu_b_d       = alu_b_q;
    result_d      = result_q;
    regs_d        = regs_q;
    instr_ready_d = instr_ready_q;
    wb_valid_d    = 1'b0;
    wb_rd_d       = wb_rd_q;
    wb_data_d     = wb_data_q;
    halted_d      = halted_q;
    illegal_d     = 1'b0;
`ifdef ALU_EXEC_CTRL_RETIRE_CNT_EN
    cnt_d         = cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (instr_valid && instr_ready_q) begin
          instr_d       = instr;
          instr_ready_d = 1'b0;
          state_d       = S_READ;
        end else begin
          state_d       = S_IDLE;
        end
      end
      S_READ: begin
        alu_op_d = op_s;
        alu_a_d  = regs_q[rd_s];
        if (op_s[3] == 1'b0) begin
          alu_b_d = regs_q[rs_s];
        end else begin
          alu_b_d = imm_s;
        end
        state_d = S_EXEC;
      end
      S_EXEC: begin
        // Pulses are registered here so they are high during exactly the WB cycle.
        result_d = alu_out;
        if (is_write(op_s)) begin
          wb_valid_d = 1'b1;
          wb_rd_d    = rd_s;
          wb_data_d  = alu_out;
        end else begin
          wb_valid_d = 1'b0;
        end
        illegal_d = is_undef(op_s);
        state_d   = S_WB;
      end
      S_WB: begin
        if (is_write(op_s)) begin
          regs_d[rd_s] = result_q;
        end else begin
          regs_d = regs_q;
        end
`ifdef ALU_EXEC_CTRL_RETIRE_CNT_EN
        if (cnt_q != 16'hFFFF) begin
          cnt_d = cnt_q + 16'd1;
        end else begin
          cnt_d = cnt_q;
        end
`endif
        if (op_s == OP_HALT) begin
          halted_d = 1'b1;
          state_d  = S_HALT;
        end else begin
          alu_op_d      = OP_NOP;
          alu_a_d       = {DW{1'b0}};
          alu_b_d       = {DW{1'b0}};
          instr_ready_d = 1'b1;
          state_d       = S_IDLE;
        end
      end
      S_HALT: begin
        instr_ready_d = 1'b0;
        state_d       = S_HALT;
      end
      default: begin
        instr_ready_d = 1'b1;
        state_d       = S_IDLE;
      end
    endcase
  end

  // Controller state, register file and registered outputs with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      instr_q       <= 17'h00000;
      alu_op_q      <= OP_NOP;
      alu_a_q       <= {DW{1'b0}};
      alu_b_q       <= {DW{1'b0}};
      result_q      <= {DW{1'b0}};
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= {DW{1'b0}};
      end
      instr_ready_q <= 1'b1;
      wb_valid_q    <= 1'b0;
      wb_rd_q       <= '0;
      wb_data_q     <= {DW{1'b0}};
      halted_q      <= 1'b0;
      illegal_q     <= 1'b0;
`ifdef ALU_EXEC_CTRL_RETIRE_CNT_EN
      cnt_q         <= 16'h0000;
`endif
    end else begin
      state_q       <= state_d;
      instr_q       <= instr_d;
      alu_op_q      <= alu_op_d;
      alu_a_q       <= alu_a_d;
      alu_b_q       <= alu_b_d;
      result_q      <= result_d;
      regs_q        <= regs_d;
      instr_ready_q <= instr_ready_d;
      wb_valid_q    <= wb_valid_d;
      wb_rd_q       <= wb_rd_d;
      wb_data_q     <= wb_data_d;
      halted_q      <= halted_d;
      illegal_q     <= illegal_d;
`ifdef ALU_EXEC_CTRL_RETIRE_CNT_EN
      cnt_q         <= cnt_d;
`endif
    end
  end

  assign instr_ready = instr_ready_q;
  assign alu_op      = alu_op_q;
  assign alu_a       = alu_a_q;
  assign alu_b       = alu_b_q;
  assign wb_valid    = wb_valid_q;
  assign wb_rd       = wb_rd_q;
  assign wb_data     = wb_data_q;
  assign halted      = halted_q;
  assign illegal     = illegal_q;

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Directed bench for alu_exec_ctrl with a small behavioural ALU attached to the operand bus.
module tb_alu_exec_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        instr_valid;
  logic        instr_ready;
  logic [16:0] instr;
  logic [3:0]  alu_op;
  logic [8:0]  alu_a, alu_b, alu_out;
  logic        wb_valid;
  logic [1:0]  wb_rd;
  logic [8:0]  wb_data;
  logic        halted, illegal;
  logic [15:0] retired_cnt;

  int n_cmp = 0;
  int n_fail = 0;
  int exp_retired = 0;

`ifdef ALU_EXEC_CTRL_RETIRE_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  // Values captured by exec_instr for the test tasks to compare.
  logic       obs_ready, obs_early, obs_hold, obs_ready_after, obs_wbv_after;
  logic [3:0] obs_op;
  logic [8:0] obs_a, obs_b, obs_wbd;
  logic       obs_wbv, obs_ill;
  logic [1:0] obs_wbr;
  logic [21:0] obs_idle_bus;

  alu_exec_ctrl dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_out(alu_out),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .halted(halted),
    .illegal(illegal), .retired_cnt(retired_cnt)
  );

  always #5 clk = ~clk;

  // Bench ALU: 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 1000 ADDI, 1001 ANDI, 1010 MOVI.
  always_comb begin
    case (alu_op)
      4'b0000, 4'b1000: alu_out = alu_a + alu_b;
      4'b0001:          alu_out = alu_a - alu_b;
      4'b0010, 4'b1001: alu_out = alu_a & alu_b;
      4'b0011:          alu_out = alu_a | alu_b;
      4'b0100:          alu_out = alu_a ^ alu_b;
      4'b1010:          alu_out = alu_b;
      default:          alu_out = 9'h155;
    endcase
  end

  function automatic logic [16:0] mk(input logic [3:0] op, input logic [1:0] rd,
                                     input logic [1:0] rs, input logic [8:0] imm);
    return {op, rd, rs, imm};
  endfunction

  function automatic logic [15:0] cnt_exp(input int n);
    return CNT_EN ? 16'(n) : 16'h0000;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic exec_instr(input logic [16:0] word);
    obs_ready   = instr_ready;
    instr_valid = 1'b1;
    instr       = word;
    step();
    instr_valid = 1'b0;
    instr       = 17'h1FFFF;
    obs_early   = wb_valid | illegal | instr_ready;
    step();
    obs_op = alu_op; obs_a = alu_a; obs_b = alu_b;
    obs_early = obs_early | wb_valid | illegal;
    step();
    obs_wbv = wb_valid; obs_wbr = wb_rd; obs_wbd = wb_data; obs_ill = illegal;
    obs_hold = (alu_op == obs_op) && (alu_a == obs_a) && (alu_b == obs_b);
    step();
    obs_ready_after = instr_ready;
    obs_wbv_after   = wb_valid | illegal;
    obs_idle_bus    = {alu_op, alu_a, alu_b};
    exp_retired++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; instr_valid = 1'b0; instr = 17'h00000;
    step(); step();
    rst_n = 1'b1;
    n_cmp++; if (instr_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got=%b exp=1", instr_ready); end
    n_cmp++; if ({alu_op, alu_a, alu_b} !== {4'b1011, 9'h000, 9'h000}) begin n_fail++; $display("FAIL reset_bus got=%h/%h/%h exp=b/0/0", alu_op, alu_a, alu_b); end
    n_cmp++; if ({wb_valid, wb_rd, wb_data, halted, illegal} !== 14'h0000) begin n_fail++; $display("FAIL reset_wb got=%b/%h/%h/%b/%b exp=0", wb_valid, wb_rd, wb_data, halted, illegal); end
    n_cmp++; if (retired_cnt !== 16'h0000) begin n_fail++; $display("FAIL reset_cnt got=%h exp=0", retired_cnt); end
    exec_instr(mk(4'b0000, 2'd0, 2'd1, 9'h000));
    n_cmp++; if ({obs_a, obs_b} !== 18'h0) begin n_fail++; $display("FAIL reset_r0r1 got=%h/%h exp=0/0", obs_a, obs_b); end
    exec_instr(mk(4'b0000, 2'd2, 2'd3, 9'h000));
    n_cmp++; if ({obs_a, obs_b} !== 18'h0) begin n_fail++; $display("FAIL reset_r2r3 got=%h/%h exp=0/0", obs_a, obs_b); end
  endtask

  task automatic test_movi();
    exec_instr(mk(4'b1010, 2'd1, 2'd0, 9'h1FF));
    n_cmp++; if (obs_ready !== 1'b1) begin n_fail++; $display("FAIL movi_ready got=%b exp=1", obs_ready); end
    n_cmp++; if (obs_early !== 1'b0) begin n_fail++; $display("FAIL movi_early got=%b exp=0", obs_early); end
    n_cmp++; if ({obs_wbv, obs_wbr, obs_wbd} !== {1'b1, 2'd1, 9'h1FF}) begin n_fail++; $display("FAIL movi_wb got=%b/%h/%h exp=1/1/1ff", obs_wbv, obs_wbr, obs_wbd); end
    n_cmp++; if ({obs_ready_after, obs_wbv_after} !== 2'b10) begin n_fail++; $display("FAIL movi_after got=%b/%b exp=1/0", obs_ready_after, obs_wbv_after); end
    n_cmp++; if (obs_idle_bus !== {4'b1011, 18'h0}) begin n_fail++; $display("FAIL movi_idle_bus got=%h exp=%h", obs_idle_bus, {4'b1011, 18'h0}); end
    n_cmp++; if (retired_cnt !== cnt_exp(exp_retired)) begin n_fail++; $display("FAIL movi_cnt got=%h exp=%h", retired_cnt, cnt_exp(exp_retired)); end
  endtask

  task automatic test_addi_wrap();
    exec_instr(mk(4'b1000, 2'd1, 2'd0, 9'h001));
    n_cmp++; if ({obs_op, obs_a, obs_b} !== {4'b1000, 9'h1FF, 9'h001}) begin n_fail++; $display("FAIL addi_bus got=%h/%h/%h exp=8/1ff/001", obs_op, obs_a, obs_b); end
    n_cmp++; if (obs_hold !== 1'b1) begin n_fail++; $display("FAIL addi_hold got=%b exp=1", obs_hold); end
    n_cmp++; if ({obs_wbv, obs_wbr, obs_wbd} !== {1'b1, 2'd1, 9'h000}) begin n_fail++; $display("FAIL addi_wb got=%b/%h/%h exp=1/1/000", obs_wbv, obs_wbr, obs_wbd); end
    exec_instr(mk(4'b0000, 2'd0, 2'd1, 9'h000));
    n_cmp++; if (obs_b !== 9'h000) begin n_fail++; $display("FAIL addi_r1 got=%h exp=000", obs_b); end
  endtask

  task automatic test_sub_nop();
    exec_instr(mk(4'b1010, 2'd2, 2'd0, 9'h005));
    exec_instr(mk(4'b1010, 2'd3, 2'd0, 9'h007));
    exec_instr(mk(4'b0001, 2'd2, 2'd3, 9'h0AB));
    n_cmp++; if ({obs_a, obs_b} !== {9'h005, 9'h007}) begin n_fail++; $display("FAIL sub_ops got=%h/%h exp=005/007", obs_a, obs_b); end
    n_cmp++; if ({obs_wbv, obs_wbr, obs_wbd} !== {1'b1, 2'd2, 9'h1FE}) begin n_fail++; $display("FAIL sub_wb got=%b/%h/%h exp=1/2/1fe", obs_wbv, obs_wbr, obs_wbd); end
    exec_instr(mk(4'b1011, 2'd2, 2'd3, 9'h000));
    n_cmp++; if ({obs_wbv, obs_ill, obs_early} !== 3'b000) begin n_fail++; $display("FAIL nop_wb got=%b/%b/%b exp=0/0/0", obs_wbv, obs_ill, obs_early); end
    exec_instr(mk(4'b0011, 2'd0, 2'd2, 9'h000));
    n_cmp++; if (obs_b !== 9'h1FE) begin n_fail++; $display("FAIL nop_r2 got=%h exp=1fe", obs_b); end
  endtask

  task automatic test_back_to_back();
    logic [16:0] prog [3];
    int          acc [3];
    int          idx;
    logic [13:0] wbv_mask, ill_mask;
    logic [8:0]  d3, d7;
    prog[0] = mk(4'b1010, 2'd0, 2'd0, 9'h0AA);
    prog[1] = mk(4'b1000, 2'd0, 2'd0, 9'h00F);
    prog[2] = mk(4'b1100, 2'd1, 2'd0, 9'h000);
    idx = 0; wbv_mask = '0; ill_mask = '0; d3 = '0; d7 = '0;
    acc[0] = -1; acc[1] = -1; acc[2] = -1;
    instr_valid = 1'b1;
    instr = prog[0];
    for (int c = 0; c < 14; c++) begin
      wbv_mask[c] = wb_valid;
      ill_mask[c] = illegal;
      if (c == 3) d3 = wb_data;
      if (c == 7) d7 = wb_data;
      if (instr_ready && instr_valid && idx < 3) begin
        acc[idx] = c;
        idx++;
      end
      step();
      if (idx < 3) instr = prog[idx];
      else instr_valid = 1'b0;
    end
    instr_valid = 1'b0;
    exp_retired += 3;
    n_cmp++; if ({acc[0], acc[1], acc[2]} !== {32'd0, 32'd4, 32'd8}) begin n_fail++; $display("FAIL b2b_accept got=%0d,%0d,%0d exp=0,4,8", acc[0], acc[1], acc[2]); end
    n_cmp++; if (wbv_mask !== 14'h0088) begin n_fail++; $display("FAIL b2b_wbv got=%h exp=0088", wbv_mask); end
    n_cmp++; if (ill_mask !== 14'h0800) begin n_fail++; $display("FAIL b2b_illegal got=%h exp=0800", ill_mask); end
    n_cmp++; if ({d3, d7} !== {9'h0AA, 9'h0B9}) begin n_fail++; $display("FAIL b2b_data got=%h/%h exp=0aa/0b9", d3, d7); end
    n_cmp++; if (retired_cnt !== cnt_exp(exp_retired)) begin n_fail++; $display("FAIL b2b_cnt got=%h exp=%h", retired_cnt, cnt_exp(exp_retired)); end
    exec_instr(mk(4'b0000, 2'd3, 2'd1, 9'h000));
    n_cmp++; if ({obs_a, obs_b, obs_wbd} !== {9'h007, 9'h000, 9'h007}) begin n_fail++; $display("FAIL illegal_nowrite got=%h/%h/%h exp=007/000/007", obs_a, obs_b, obs_wbd); end
  endtask

  task automatic test_halt();
    logic seen_ready, seen_wb, lost_halt;
    exec_instr(mk(4'b1111, 2'd0, 2'd0, 9'h000));
    n_cmp++; if ({obs_wbv, obs_ill, obs_ready_after} !== 3'b000) begin n_fail++; $display("FAIL halt_wb got=%b/%b/%b exp=0/0/0", obs_wbv, obs_ill, obs_ready_after); end
    n_cmp++; if ({halted, alu_op} !== {1'b1, 4'b1111}) begin n_fail++; $display("FAIL halt_state got=%b/%h exp=1/f", halted, alu_op); end
    n_cmp++; if (retired_cnt !== cnt_exp(exp_retired)) begin n_fail++; $display("FAIL halt_cnt got=%h exp=%h", retired_cnt, cnt_exp(exp_retired)); end
    seen_ready = 1'b0; seen_wb = 1'b0; lost_halt = 1'b0;
    instr_valid = 1'b1;
    instr = mk(4'b1010, 2'd2, 2'd0, 9'h123);
    for (int c = 0; c < 6; c++) begin
      step();
      seen_ready = seen_ready | instr_ready;
      seen_wb    = seen_wb | wb_valid;
      lost_halt  = lost_halt | ~halted;
    end
    instr_valid = 1'b0;
    n_cmp++; if ({seen_ready, seen_wb, lost_halt} !== 3'b000) begin n_fail++; $display("FAIL halt_frozen got=%b/%b/%b exp=0/0/0", seen_ready, seen_wb, lost_halt); end
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    exp_retired = 0;
    n_cmp++; if ({instr_ready, alu_op, alu_a, alu_b, wb_valid, wb_rd, wb_data, halted, illegal, retired_cnt} !==
                 {1'b1, 4'b1011, 9'h000, 9'h000, 1'b0, 2'b00, 9'h000, 1'b0, 1'b0, 16'h0000}) begin
      n_fail++; $display("FAIL halt_reset got=%b/%h/%h/%h/%b/%h/%h/%b/%b/%h", instr_ready, alu_op, alu_a, alu_b, wb_valid, wb_rd, wb_data, halted, illegal, retired_cnt);
    end
    exec_instr(mk(4'b0000, 2'd0, 2'd1, 9'h000));
    n_cmp++; if ({obs_a, obs_b} !== 18'h0) begin n_fail++; $display("FAIL halt_r0r1 got=%h/%h exp=0/0", obs_a, obs_b); end
    exec_instr(mk(4'b0000, 2'd2, 2'd3, 9'h000));
    n_cmp++; if ({obs_a, obs_b} !== 18'h0) begin n_fail++; $display("FAIL halt_r2r3 got=%h/%h exp=0/0", obs_a, obs_b); end
  endtask

  task automatic test_reset_mid();
    logic seen_wb;
    instr_valid = 1'b1;
    instr = mk(4'b1000, 2'd3, 2'd0, 9'h010);
    step();
    instr_valid = 1'b0;
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    exp_retired = 0;
    n_cmp++; if ({wb_valid, instr_ready} !== 2'b01) begin n_fail++; $display("FAIL mid_reset got=%b/%b exp=0/1", wb_valid, instr_ready); end
    n_cmp++; if (retired_cnt !== 16'h0000) begin n_fail++; $display("FAIL mid_cnt got=%h exp=0", retired_cnt); end
    seen_wb = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      seen_wb = seen_wb | wb_valid;
    end
    n_cmp++; if (seen_wb !== 1'b0) begin n_fail++; $display("FAIL mid_nowb got=%b exp=0", seen_wb); end
    exec_instr(mk(4'b0000, 2'd0, 2'd3, 9'h000));
    n_cmp++; if (obs_b !== 9'h000) begin n_fail++; $display("FAIL mid_r3 got=%h exp=000", obs_b); end
    n_cmp++; if (retired_cnt !== cnt_exp(exp_retired)) begin n_fail++; $display("FAIL mid_cnt_after got=%h exp=%h", retired_cnt, cnt_exp(exp_retired)); end
  endtask

  initial begin
    test_reset();
    test_movi();
    test_addi_wrap();
    test_sub_nop();
    test_back_to_back();
    test_halt();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
